// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the mARC control unit: state bit positions, one-hot
// state vectors, instruction classes, branch conditions, trap causes and PSR
// flag positions. Used by both the sequencer and the output logic.
package marc_ctrl_pkg;

    localparam int NUM_STATES = 13;

    // Bit index of each state within the one-hot state vector
    localparam int S_FETCH     = 0;
    localparam int S_IDLE      = 1;
    localparam int S_DECODE    = 2;
    localparam int S_ALU_REG   = 3;
    localparam int S_ALU_IMM   = 4;
    localparam int S_MEM       = 5;
    localparam int S_BR_EVAL   = 6;
    localparam int S_BR_TAKE   = 7;
    localparam int S_TRAP      = 8;
    localparam int S_CALL_LINK = 9;
    localparam int S_CALL_JUMP = 10;
    localparam int S_JMPL      = 11;
    localparam int S_PC_INC    = 12;

    typedef logic [NUM_STATES-1:0] state_vec_t;

    localparam state_vec_t ST_FETCH     = state_vec_t'(1) << S_FETCH;
    localparam state_vec_t ST_IDLE      = state_vec_t'(1) << S_IDLE;
    localparam state_vec_t ST_DECODE    = state_vec_t'(1) << S_DECODE;
    localparam state_vec_t ST_ALU_REG   = state_vec_t'(1) << S_ALU_REG;
    localparam state_vec_t ST_ALU_IMM   = state_vec_t'(1) << S_ALU_IMM;
    localparam state_vec_t ST_MEM       = state_vec_t'(1) << S_MEM;
    localparam state_vec_t ST_BR_EVAL   = state_vec_t'(1) << S_BR_EVAL;
    localparam state_vec_t ST_BR_TAKE   = state_vec_t'(1) << S_BR_TAKE;
    localparam state_vec_t ST_TRAP      = state_vec_t'(1) << S_TRAP;
    localparam state_vec_t ST_CALL_LINK = state_vec_t'(1) << S_CALL_LINK;
    localparam state_vec_t ST_CALL_JUMP = state_vec_t'(1) << S_CALL_JUMP;
    localparam state_vec_t ST_JMPL      = state_vec_t'(1) << S_JMPL;
    localparam state_vec_t ST_PC_INC    = state_vec_t'(1) << S_PC_INC;

    // PSR flag positions within status[4:0] = {IE, C, V, N, Z}
    localparam int PSR_Z  = 0;
    localparam int PSR_N  = 1;
    localparam int PSR_V  = 2;
    localparam int PSR_C  = 3;
    localparam int PSR_IE = 4;

    // Opcode field ir[14:12] codes
    localparam logic [2:0] OP0_MEM    = 3'b111;
    localparam logic [2:0] OP1_BRANCH = 3'b000;
    localparam logic [2:0] OP1_CALL   = 3'b001;
    localparam logic [2:0] OP1_JMPL   = 3'b010;
    localparam logic [2:0] OP1_RETURN = 3'b011;
    localparam logic [2:0] OP1_HALT   = 3'b100;

    typedef enum logic [2:0] {
        BC_JUMP = 3'b000,
        BC_BA   = 3'b001,
        BC_BNE  = 3'b010,
        BC_BE   = 3'b011,
        BC_BG   = 3'b100,
        BC_BLE  = 3'b101,
        BC_BGE  = 3'b110,
        BC_BL   = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        TRAP_IRQ     = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_e;

    typedef enum logic [3:0] {
        CLS_ALU_REG,
        CLS_ALU_IMM,
        CLS_MEM,
        CLS_BRANCH,
        CLS_CALL,
        CLS_JMPL,
        CLS_RETURN,
        CLS_HALT,
        CLS_ILLEGAL
    } insn_class_e;

    // Classify an instruction word into the state the sequencer dispatches to
    function automatic insn_class_e decode_class(input logic [15:0] insn);
        insn_class_e cls;
        if (!insn[15]) begin
            if (insn[14:12] == OP0_MEM) begin
                cls = CLS_MEM;
            end else if (insn[4]) begin
                cls = CLS_ALU_IMM;
            end else begin
                cls = CLS_ALU_REG;
            end
        end else begin
            case (insn[14:12])
                OP1_BRANCH: cls = CLS_BRANCH;
                OP1_CALL:   cls = CLS_CALL;
                OP1_JMPL:   cls = CLS_JMPL;
                OP1_RETURN: cls = CLS_RETURN;
                OP1_HALT:   cls = CLS_HALT;
                default:    cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer_branch_cond.sv
// Branch condition evaluator: maps the 3-bit condition field and the PSR
// arithmetic flags to a single taken decision. Purely combinational.
module branch_cond
    import marc_ctrl_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_taken
);

    // Signed-compare conditions are built from "less than" = N xor V
    function automatic logic eval_cond(input br_cond_e cond, input logic [3:0] flags);
        logic z;
        logic lt;
        logic taken;
        z  = flags[PSR_Z];
        lt = flags[PSR_N] ^ flags[PSR_V];
        case (cond)
            BC_JUMP, BC_BA: taken = 1'b1;
            BC_BNE:         taken = ~z;
            BC_BE:          taken = z;
            BC_BG:          taken = ~z & ~lt;
            BC_BLE:         taken = z | lt;
            BC_BGE:         taken = ~lt;
            BC_BL:          taken = lt;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Evaluate the selected condition against the current flags
    always_comb begin
        o_taken = eval_cond(br_cond_e'(i_cond), i_flags);
    end

endmodule

// File: rtl/control_sequencer.sv
// mARC control sequencer: one-hot next-state machine stepping fetch, decode
// and execute, sequencing memory handshakes under a wait-state watchdog and
// entering TRAP on interrupts, illegal opcodes and bus timeouts.
module control_sequencer
    import marc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic [4:0]  status,
    input  logic        irq,
    input  logic        mem_ready,
    output logic [12:0] state,
    output logic        mem_req,
    output logic        ir_we,
    output logic        irq_ack,
    output logic [1:0]  trap_cause,
    output logic        retired
);

    // Count value whose next unanswered wait cycle reaches the timeout
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_vec_t  r_state;
    state_vec_t  w_next_state;
    state_vec_t  w_boundary;
    logic [7:0]  r_wd_cnt;
    logic        w_wd_expire;
    logic        w_mem_wait;
    logic        w_br_taken;
    trap_cause_e w_trap_cause;
    trap_cause_e r_trap_cause;
    logic        r_irq_ack;

    branch_cond u_branch_cond (
        .i_cond  (ir[10:8]),
        .i_flags (status[3:0]),
        .o_taken (w_br_taken)
    );

    assign w_wd_expire = (r_wd_cnt == WD_LAST);
    assign w_mem_wait  = mem_req & ~mem_ready;
    assign w_boundary  = run ? ST_FETCH : ST_IDLE;

    assign state      = r_state;
    assign irq_ack    = r_irq_ack;
    assign trap_cause = r_trap_cause;

    // State register; reset parks the machine in IDLE and abandons any access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and trap cause for any TRAP entry
    always_comb begin
        w_next_state = ST_IDLE;
        w_trap_cause = TRAP_IRQ;
        case (r_state)
            ST_IDLE: w_next_state = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_wd_expire) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = TRAP_TIMEOUT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (decode_class(ir))
                    CLS_MEM:     w_next_state = ST_MEM;
                    CLS_ALU_IMM: w_next_state = ST_ALU_IMM;
                    CLS_ALU_REG: w_next_state = ST_ALU_REG;
                    CLS_BRANCH:  w_next_state = ST_BR_EVAL;
                    CLS_CALL:    w_next_state = ST_CALL_LINK;
                    CLS_JMPL:    w_next_state = ST_JMPL;
                    CLS_RETURN:  w_next_state = ST_PC_INC;
                    CLS_HALT:    w_next_state = ST_IDLE;
                    default: begin
                        w_next_state = ST_TRAP;
                        w_trap_cause = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_ALU_REG, ST_ALU_IMM: w_next_state = ST_PC_INC;
            ST_MEM: begin
                if (mem_ready) begin
                    w_next_state = ST_PC_INC;
                end else if (w_wd_expire) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = TRAP_TIMEOUT;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_BR_EVAL:   w_next_state = w_br_taken ? ST_BR_TAKE : ST_PC_INC;
            ST_CALL_LINK: w_next_state = ST_CALL_JUMP;
            ST_PC_INC: begin
                if (irq && status[PSR_IE]) begin
                    w_next_state = ST_TRAP;
                    w_trap_cause = TRAP_IRQ;
                end else begin
                    w_next_state = w_boundary;
                end
            end
            ST_BR_TAKE, ST_CALL_JUMP, ST_JMPL, ST_TRAP: w_next_state = w_boundary;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register (ir_we also qualifies on mem_ready)
    always_comb begin
        mem_req = r_state[S_FETCH] | r_state[S_MEM];
        ir_we   = r_state[S_FETCH] & mem_ready;
        retired = r_state[S_PC_INC] | r_state[S_BR_TAKE]
                | r_state[S_CALL_JUMP] | r_state[S_JMPL];
    end

    // Watchdog: counts unanswered wait cycles, restarts whenever an access starts or ends
    always_ff @(posedge clk) begin
        if (rst || !w_mem_wait || (w_next_state != r_state)) begin
            r_wd_cnt <= 8'd0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end
    end

    // Latch the trap cause and pulse irq_ack on an interrupt-driven TRAP entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_cause <= TRAP_IRQ;
            r_irq_ack    <= 1'b0;
        end else begin
            r_irq_ack <= (w_next_state == ST_TRAP) && (w_trap_cause == TRAP_IRQ);
            if (w_next_state == ST_TRAP) begin
                r_trap_cause <= w_trap_cause;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Each instruction is expanded
// into its expected per-cycle trace (state, handshake outputs) from the
// instruction-level rules, and the DUT is driven and checked cycle by cycle.
module tb_control_sequencer;

    localparam int TO = 15;

    localparam int FETCH = 0, IDLE = 1, DECODE = 2, ALU_REG = 3, ALU_IMM = 4;
    localparam int MEM = 5, BR_EVAL = 6, BR_TAKE = 7, TRAP = 8, CALL_LINK = 9;
    localparam int CALL_JUMP = 10, JMPL = 11, PC_INC = 12;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic [4:0]  status;
    logic        irq;
    logic        mem_ready;
    logic [12:0] state;
    logic        mem_req;
    logic        ir_we;
    logic        irq_ack;
    logic [1:0]  trap_cause;
    logic        retired;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir         (ir),
        .status     (status),
        .irq        (irq),
        .mem_ready  (mem_ready),
        .state      (state),
        .mem_req    (mem_req),
        .ir_we      (ir_we),
        .irq_ack    (irq_ack),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ir;
        logic [4:0]  st;
        logic        irq;
        logic        rdy;
        logic        run;
        int          sidx;
        logic        we;
        logic        ack;
        logic [1:0]  cause;
    } cyc_t;

    cyc_t        plan[$];
    logic [15:0] cur_ir;
    logic [4:0]  cur_st;
    logic [1:0]  m_cause;
    int          n_cmp;
    int          n_bad;
    int          cyc;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int sidx, input logic rdy, input logic irq_v,
                        input logic run_v, input logic we, input logic ack);
        cyc_t c;
        c.ir    = cur_ir;
        c.st    = cur_st;
        c.irq   = irq_v;
        c.rdy   = rdy;
        c.run   = run_v;
        c.sidx  = sidx;
        c.we    = we;
        c.ack   = ack;
        c.cause = m_cause;
        plan.push_back(c);
    endtask

    // n idle cycles with run low, then one with run high to leave IDLE
    task automatic idle_tail(input int n);
        repeat (n) push(IDLE, rb(), rb(), 1'b0, 1'b0, 1'b0);
        push(IDLE, rb(), rb(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic leave(input int sidx, input logic irq_v, input logic run_after);
        push(sidx, rb(), irq_v, run_after, 1'b0, 1'b0);
        if (!run_after) idle_tail($urandom_range(0, 2));
    endtask

    task automatic do_trap(input logic [1:0] cause, input logic run_after);
        m_cause = cause;
        push(TRAP, rb(), rb(), run_after, 1'b0, cause == 2'd0);
        if (!run_after) idle_tail($urandom_range(0, 2));
    endtask

    task automatic pc_inc(input logic irq_pc, input logic run_after);
        if (irq_pc && cur_st[4]) begin
            push(PC_INC, rb(), 1'b1, rb(), 1'b0, 1'b0);
            do_trap(2'd0, run_after);
        end else begin
            leave(PC_INC, irq_pc, run_after);
        end
    endtask

    // A memory access: 'waits' cycles without ready, then the ready cycle,
    // unless the wait budget runs out first
    task automatic access(input int sidx, input int waits, output bit to);
        int n;
        n = (waits < TO) ? waits : TO;
        repeat (n) push(sidx, 1'b0, rb(), rb(), 1'b0, 1'b0);
        if (waits >= TO) begin
            to = 1'b1;
        end else begin
            push(sidx, 1'b1, rb(), rb(), sidx == FETCH, 1'b0);
            to = 1'b0;
        end
    endtask

    function automatic bit taken(input logic [2:0] cond, input logic [4:0] st);
        bit z, lt;
        z  = st[0];
        lt = (st[1] != st[2]);
        case (cond)
            3'd0, 3'd1: return 1'b1;
            3'd2:       return !z;
            3'd3:       return z;
            3'd4:       return !z && !lt;
            3'd5:       return z || lt;
            3'd6:       return !lt;
            default:    return lt;
        endcase
    endfunction

    // Expand one instruction, starting in FETCH, into its expected trace
    task automatic insn(input logic [15:0] w, input logic [4:0] st, input int fw,
                        input int mw, input logic irq_pc, input logic run_after);
        bit to;
        cur_ir = w;
        cur_st = st;
        access(FETCH, fw, to);
        if (to) begin
            do_trap(2'd2, run_after);
            return;
        end
        push(DECODE, rb(), rb(), rb(), 1'b0, 1'b0);
        if (!w[15]) begin
            if (w[14:12] == 3'b111) begin
                access(MEM, mw, to);
                if (to) do_trap(2'd2, run_after);
                else    pc_inc(irq_pc, run_after);
            end else begin
                push(w[4] ? ALU_IMM : ALU_REG, rb(), rb(), rb(), 1'b0, 1'b0);
                pc_inc(irq_pc, run_after);
            end
        end else begin
            case (w[14:12])
                3'd0: begin
                    push(BR_EVAL, rb(), rb(), rb(), 1'b0, 1'b0);
                    if (taken(w[10:8], st)) leave(BR_TAKE, rb(), run_after);
                    else                    pc_inc(irq_pc, run_after);
                end
                3'd1: begin
                    push(CALL_LINK, rb(), rb(), rb(), 1'b0, 1'b0);
                    leave(CALL_JUMP, rb(), run_after);
                end
                3'd2:    leave(JMPL, rb(), run_after);
                3'd3:    pc_inc(irq_pc, run_after);
                3'd4:    idle_tail($urandom_range(0, 2));
                default: do_trap(2'd1, run_after);
            endcase
        end
    endtask

    // Drive each planned cycle and compare the DUT against the expected trace
    task automatic play();
        cyc_t c;
        logic [12:0] ev;
        logic        er;
        logic        em;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            ir        = c.ir;
            status    = c.st;
            irq       = c.irq;
            mem_ready = c.rdy;
            run       = c.run;
            #1;
            ev = 13'd1 << c.sidx;
            em = (c.sidx == FETCH) || (c.sidx == MEM);
            er = (c.sidx == PC_INC) || (c.sidx == BR_TAKE) ||
                 (c.sidx == CALL_JUMP) || (c.sidx == JMPL);
            chk("state", {3'b0, state}, {3'b0, ev});
            chk("req_we_ret_ack_cause",
                {10'b0, mem_req, ir_we, retired, irq_ack, trap_cause},
                {10'b0, em, c.we, er, c.ack, c.cause});
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return TO;
        if (r == 1) return TO - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        m_cause = 2'd0;
        cur_ir = 16'h0;
        cur_st = 5'h0;
        rst = 1'b1;
        run = 1'b0;
        ir = 16'h0;
        status = 5'h0;
        irq = 1'b0;
        mem_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", {3'b0, state}, 16'h0002);
        chk("rst_mem_req", {15'b0, mem_req}, 16'h0);
        chk("rst_ir_we", {15'b0, ir_we}, 16'h0);
        chk("rst_irq_ack", {15'b0, irq_ack}, 16'h0);
        chk("rst_retired", {15'b0, retired}, 16'h0);
        chk("rst_trap_cause", {14'b0, trap_cause}, 16'h0);
        rst = 1'b0;

        // Zero-wait ALU_REG: IDLE, FETCH, DECODE, ALU_REG, PC_INC, FETCH
        idle_tail(0);
        insn(16'h1005, 5'h00, 0, 0, 1'b0, 1'b1);
        // Three fetch wait cycles
        insn(16'h1005, 5'h00, 3, 0, 1'b0, 1'b1);
        // bne with Z=1 falls through, with Z=0 is taken
        insn(16'h8200, 5'h01, 0, 0, 1'b0, 1'b1);
        insn(16'h8200, 5'h00, 0, 0, 1'b0, 1'b1);
        // Illegal opcode, then interrupt taken at PC_INC of an ALU_IMM
        insn(16'hF000, 5'h10, 0, 0, 1'b1, 1'b1);
        insn(16'h1015, 5'h10, 0, 0, 1'b1, 1'b1);
        // Interrupt masked by IE=0
        insn(16'h1015, 5'h00, 1, 0, 1'b1, 1'b1);
        // Load timeout, load ready on the last allowed cycle, fetch timeout
        insn(16'h7000, 5'h00, 0, TO, 1'b0, 1'b1);
        insn(16'h7000, 5'h00, 0, TO - 1, 1'b0, 1'b1);
        insn(16'h1005, 5'h00, TO, 0, 1'b0, 1'b1);
        // Store with run dropped: completes, then parks in IDLE
        insn(16'h7800, 5'h00, 0, 3, 1'b0, 1'b0);
        // Call, jmpl, return, halt
        insn(16'h9000, 5'h00, 0, 0, 1'b0, 1'b1);
        insn(16'hA000, 5'h00, 0, 0, 1'b0, 1'b1);
        insn(16'hB000, 5'h10, 0, 0, 1'b0, 1'b1);
        insn(16'hC000, 5'h00, 0, 0, 1'b0, 1'b1);
        play();

        // Reset during a fetch wait abandons the access
        cur_ir = 16'h1005;
        push(FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        play();
        rst = 1'b1;
        mem_ready = 1'b0;
        run = 1'b1;
        @(negedge clk);
        #1;
        chk("midfetch_rst_state", {3'b0, state}, 16'h0002);
        chk("midfetch_rst_mem_req", {15'b0, mem_req}, 16'h0);
        chk("midfetch_rst_cause", {14'b0, trap_cause}, 16'h0);
        rst = 1'b0;
        m_cause = 2'd0;
        idle_tail(1);
        play();

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            insn(16'($urandom), 5'($urandom), pick_wait(), pick_wait(),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
            play();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
